// File: rtl/multibyte_add_sequencer_if.sv
// rtl/multibyte_add_sequencer_if.sv - operand/result handshakes and byte-adder bus for the sequencer
interface multibyte_add_sequencer_if #(
  parameter int NUM_BYTES = 4
);
  localparam int W = 8 * NUM_BYTES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic [7:0]   add_a;
  logic [7:0]   add_b;
  logic         add_cin;
  logic [7:0]   add_sum;
  logic         add_cout;

  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready, add_sum, add_cout,
    input  in_ready, out_valid, out_sum, out_cout, add_a, add_b, add_cin
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready, add_sum, add_cout,
    output in_ready, out_valid, out_sum, out_cout, add_a, add_b, add_cin
  );
endinterface

// File: rtl/multibyte_add_sequencer.sv
// rtl/multibyte_add_sequencer.sv - feeds an external 8-bit adder byte by byte to add wide operands
module multibyte_add_sequencer #(
  parameter int NUM_BYTES = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  multibyte_add_sequencer_if.slave  bus
);
  localparam int W  = 8 * NUM_BYTES;
  localparam int IW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_BYTES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  state_t        state_next;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic [W-1:0]  sum_reg;
  logic          carry_reg;
  logic [IW-1:0] idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next    = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_sum   = '0;
    bus.out_cout  = 1'b0;
    bus.add_a     = 8'h00;
    bus.add_b     = 8'h00;
    bus.add_cin   = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          state_next = RUN;
        end
      end
      RUN: begin
        bus.add_a   = a_reg[{idx, 3'b000} +: 8];
        bus.add_b   = b_reg[{idx, 3'b000} +: 8];
        bus.add_cin = carry_reg;
        if (idx == LAST) begin
          state_next = DONE;
        end
      end
      DONE: begin
        bus.out_valid = 1'b1;
        bus.out_sum   = sum_reg;
        bus.out_cout  = carry_reg;
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Every byte of sum_reg is rewritten in RUN, so it needs no clearing on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      idx       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_reg     <= bus.in_a;
            b_reg     <= bus.in_b;
            carry_reg <= bus.in_cin;
            idx       <= '0;
          end
        end
        RUN: begin
          sum_reg[{idx, 3'b000} +: 8] <= bus.add_sum;
          carry_reg                   <= bus.add_cout;
          idx                         <= (idx == LAST) ? '0 : idx + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end
endmodule

// File: tb/tb_multibyte_add_sequencer.sv
// tb/tb_multibyte_add_sequencer.sv - self-checking bench for multibyte_add_sequencer (4-byte and 1-byte)
module tb_multibyte_add_sequencer;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   cyc;

  multibyte_add_sequencer_if #(.NUM_BYTES(4)) bus ();
  multibyte_add_sequencer_if #(.NUM_BYTES(1)) bus1 ();

  multibyte_add_sequencer #(.NUM_BYTES(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  multibyte_add_sequencer #(.NUM_BYTES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  // Ideal combinational 8-bit adders
  logic [8:0] s4;
  logic [8:0] s1;
  assign s4 = {1'b0, bus.add_a} + {1'b0, bus.add_b} + 9'(bus.add_cin);
  assign bus.add_sum  = s4[7:0];
  assign bus.add_cout = s4[8];
  assign s1 = {1'b0, bus1.add_a} + {1'b0, bus1.add_b} + 9'(bus1.add_cin);
  assign bus1.add_sum  = s1[7:0];
  assign bus1.add_cout = s1[8];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Model state for the 4-byte instance
  logic [63:0] exp_q[$];
  logic [63:0] a_cur, b_cur, cin_cur;
  logic [63:0] last_result;
  logic [63:0] prev_res;
  logic [7:0]  trace_a[$];
  logic        trace_cin[$];
  int          run_k;
  int          acc_cyc;
  logic        prev_v, prev_r;
  bit          rand_stall;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      run_k  = 0;
      prev_v = 1'b0;
      prev_r = 1'b0;
    end else begin
      logic [63:0] mask, res, ea, eb, ec;
      res = {31'b0, bus.out_cout, bus.out_sum};
      chk("ready_valid_excl", {63'b0, bus.in_ready & bus.out_valid}, 64'd0);
      if (!bus.in_ready && !bus.out_valid) begin
        mask = (64'd1 << (8 * run_k)) - 64'd1;
        ea = (a_cur >> (8 * run_k)) & 64'hFF;
        eb = (b_cur >> (8 * run_k)) & 64'hFF;
        ec = (((a_cur & mask) + (b_cur & mask) + cin_cur) >> (8 * run_k)) & 64'd1;
        chk("run_add_a", {56'b0, bus.add_a}, ea);
        chk("run_add_b", {56'b0, bus.add_b}, eb);
        chk("run_add_cin", {63'b0, bus.add_cin}, ec);
        trace_a.push_back(bus.add_a);
        trace_cin.push_back(bus.add_cin);
        run_k++;
      end else begin
        chk("idle_adder_bus", {47'b0, bus.add_a, bus.add_b, bus.add_cin}, 64'd0);
        run_k = 0;
      end
      if (bus.out_valid && !prev_v) begin
        chk("latency", 64'(cyc - acc_cyc), 64'd5);
        chk("valid_has_op", 64'(exp_q.size() != 0), 64'd1);
      end
      if (bus.out_valid && prev_v && !prev_r)
        chk("hold_stable", res, prev_res);
      if (bus.out_valid && bus.out_ready && exp_q.size() != 0) begin
        chk("result", res, exp_q[0]);
        last_result = res;
        void'(exp_q.pop_front());
      end
      if (bus.in_valid && bus.in_ready) begin
        a_cur   = {32'b0, bus.in_a};
        b_cur   = {32'b0, bus.in_b};
        cin_cur = {63'b0, bus.in_cin};
        exp_q.push_back(a_cur + b_cur + cin_cur);
        acc_cyc = cyc;
      end
      prev_v   = bus.out_valid;
      prev_r   = bus.out_ready;
      prev_res = res;
    end
  end

  always @(posedge clk) begin
    if (rand_stall) begin
      #1 bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic send4(input logic [31:0] a, input logic [31:0] b, input logic cin);
    int t;
    t = 0;
    bus.in_a = a; bus.in_b = b; bus.in_cin = cin; bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && t < 200) begin
      t++;
      @(negedge clk);
    end
    if (t >= 200) begin
      checks++; errors++;
      $display("FAIL accept_timeout actual=in_ready_low required=accept");
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_a = $urandom; bus.in_b = $urandom; bus.in_cin = 1'b1;
  endtask

  task automatic drain4();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && t < 500) begin
      t++;
      @(posedge clk); #1;
    end
    if (t >= 500) begin
      checks++; errors++;
      $display("FAIL drain_timeout actual=pending%0d required=0", exp_q.size());
    end
  endtask

  logic [7:0]  v1_a[4]   = '{8'hFF, 8'h00, 8'h7F, 8'hFF};
  logic [7:0]  v1_b[4]   = '{8'h80, 8'h00, 8'h80, 8'hFF};
  logic        v1_c[4]   = '{1'b1, 1'b0, 1'b1, 1'b1};
  logic [8:0]  v1_e[4]   = '{9'h180, 9'h000, 9'h100, 9'h1FF};
  logic [7:0]  exp_tr_a[4] = '{8'h78, 8'h56, 8'h34, 8'h12};
  logic        exp_tr_c[4] = '{1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    int t;
    checks = 0; errors = 0; rand_stall = 0;
    acc_cyc = 0; last_result = '0; a_cur = '0; b_cur = '0; cin_cur = '0;
    bus.in_valid = 0; bus.in_a = '0; bus.in_b = '0; bus.in_cin = 0; bus.out_ready = 1;
    bus1.in_valid = 0; bus1.in_a = '0; bus1.in_b = '0; bus1.in_cin = 0; bus1.out_ready = 1;
    rst_n = 1'b0;
    #12;
    chk("reset_in_ready", {63'b0, bus.in_ready}, 64'd1);
    chk("reset_out_valid", {63'b0, bus.out_valid}, 64'd0);
    chk("reset_out", {31'b0, bus.out_cout, bus.out_sum}, 64'd0);
    chk("reset_adder_bus", {47'b0, bus.add_a, bus.add_b, bus.add_cin}, 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Carry ripples through all four bytes
    send4(32'hFFFFFFFF, 32'h00000001, 1'b0);
    drain4();
    chk("t1_result", last_result, 64'h1_0000_0000);

    // Byte order and carry chain on the adder bus
    trace_a.delete(); trace_cin.delete();
    send4(32'h12345678, 32'h11111111, 1'b1);
    drain4();
    chk("t2_result", last_result, 64'h0_2345_678A);
    chk("t2_trace_len", 64'(trace_a.size()), 64'd4);
    for (int i = 0; i < 4 && i < trace_a.size(); i++) begin
      chk($sformatf("t2_add_a%0d", i), {56'b0, trace_a[i]}, {56'b0, exp_tr_a[i]});
      chk($sformatf("t2_add_cin%0d", i), {63'b0, trace_cin[i]}, {63'b0, exp_tr_c[i]});
    end

    // Backpressure
    bus.out_ready = 1'b0;
    send4(32'h000000FF, 32'h00000001, 1'b0);
    t = 0;
    while (!bus.out_valid && t < 50) begin t++; @(negedge clk); end
    chk("bp_valid_seen", {63'b0, bus.out_valid}, 64'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", {63'b0, bus.out_valid}, 64'd1);
      chk("bp_hold_ready", {63'b0, bus.in_ready}, 64'd0);
      chk("bp_hold_sum", {31'b0, bus.out_cout, bus.out_sum}, 64'h100);
    end
    @(posedge clk); #1 bus.out_ready = 1'b1;
    @(posedge clk); #1 bus.out_ready = 1'b0;
    @(negedge clk);
    chk("bp_release_valid", {63'b0, bus.out_valid}, 64'd0);
    chk("bp_release_ready", {63'b0, bus.in_ready}, 64'd1);
    bus.out_ready = 1'b1;

    // Reset while idx == 2
    @(posedge clk); #1;
    send4(32'hAAAAAAAA, 32'h55555555, 1'b1);
    @(posedge clk); @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_in_ready", {63'b0, bus.in_ready}, 64'd1);
    chk("rst_mid_out_valid", {63'b0, bus.out_valid}, 64'd0);
    chk("rst_mid_out", {31'b0, bus.out_cout, bus.out_sum}, 64'd0);
    chk("rst_mid_adder_bus", {47'b0, bus.add_a, bus.add_b, bus.add_cin}, 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("rst_no_valid", {63'b0, bus.out_valid}, 64'd0);
    end
    @(posedge clk); #1;
    send4(32'h00000001, 32'h00000001, 1'b0);
    drain4();
    chk("post_rst_result", last_result, 64'h2);

    // Random sweep with output stalls
    rand_stall = 1;
    for (int i = 0; i < 1000; i++)
      send4($urandom, $urandom, 1'($urandom_range(0, 1)));
    drain4();
    rand_stall = 0;
    @(posedge clk); #1 bus.out_ready = 1'b1;

    // Single-byte instance
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      bus1.in_a = v1_a[i]; bus1.in_b = v1_b[i]; bus1.in_cin = v1_c[i]; bus1.in_valid = 1'b1;
      @(negedge clk);
      chk("n1_accept_ready", {63'b0, bus1.in_ready}, 64'd1);
      @(posedge clk); #1 bus1.in_valid = 1'b0; bus1.in_a = 8'h5A;
      @(negedge clk);
      chk("n1_run_bus", {47'b0, bus1.add_a, bus1.add_b, bus1.add_cin},
          {47'b0, v1_a[i], v1_b[i], v1_c[i]});
      chk("n1_run_no_valid", {63'b0, bus1.out_valid}, 64'd0);
      @(negedge clk);
      chk("n1_valid", {63'b0, bus1.out_valid}, 64'd1);
      chk("n1_result", {55'b0, bus1.out_cout, bus1.out_sum}, {55'b0, v1_e[i]});
      @(negedge clk);
      chk("n1_back_idle", {62'b0, bus1.out_valid, bus1.in_ready}, 64'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
